// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with valid/ready on both sides and a kill for pipeline flushes.
module muldiv_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  kill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_wen
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // Operation context captured at accept.
  logic            is_div_q;
  logic            sel_q;      // divide: take remainder; multiply: take high half
  logic            neg_q;      // final result must be negated
  logic [WIDTH-1:0] hi, lo, m;

  // Accept-time decode.
  logic             accept;
  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_result;

  assign accept = (state == S_IDLE) && in_valid && !kill;

  always_comb begin
    a_signed = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01 || in_op[1:0] == 2'b10);
    b_signed = in_op[2] ? !in_op[0] : (in_op[1:0] == 2'b01);
    a_neg    = a_signed && in_a[WIDTH-1];
    b_neg    = b_signed && in_b[WIDTH-1];
    a_mag    = a_neg ? -in_a : in_a;
    b_mag    = b_neg ? -in_b : in_b;
    div_zero = in_op[2] && (in_b == '0);
    div_ovf  = in_op[2] && !in_op[0] && (in_a == MOST_NEG) && (in_b == '1);
    special  = div_zero || div_ovf;
    // Divide-by-zero: quotient all-ones, remainder = dividend.
    // Signed overflow: quotient = dividend, remainder 0.
    special_result = in_a;
    if (div_zero) begin
      if (!in_op[1]) special_result = '1;
    end else if (in_op[1]) begin
      special_result = '0;
    end
  end

  // One iteration of the shared datapath.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   hi_n, lo_n;
  logic [2*WIDTH-1:0] prod_n, prod_s;
  logic [WIDTH-1:0]   div_val, calc_result;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    hi_n      = hi;
    lo_n      = lo;
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    if (is_div_q) begin
      // Restoring step: keep the trial difference only if it did not borrow.
      if (!div_diff[WIDTH]) begin
        hi_n = div_diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = div_shift[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod_n  = {hi_n, lo_n};
    prod_s  = neg_q ? -prod_n : prod_n;
    div_val = sel_q ? hi_n : lo_n;
    if (is_div_q) calc_result = neg_q ? -div_val : div_val;
    else          calc_result = sel_q ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    // NOTE: datapath registers carry no reset; state and out_valid decide whether their contents mean anything.
    if (accept) begin
      is_div_q <= in_op[2];
      sel_q    <= in_op[2] ? in_op[1] : (in_op[1:0] != 2'b00);
      neg_q    <= (in_op[2] && in_op[1]) ? a_neg : (a_neg ^ b_neg);
      hi       <= '0;
      lo       <= in_op[2] ? a_mag : b_mag;
      m        <= in_op[2] ? b_mag : a_mag;
    end else if (state == S_CALC) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            out_rd   <= in_rd;
            cnt      <= '0;
            in_ready <= 1'b0;
            if (special) begin
              out_result <= special_result;
              state      <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER) begin
              out_result <= calc_result;
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // Special-case results enter DONE with out_valid low and raise it one
          // edge later, giving them a fixed one-cycle latency.
          if (kill || (out_valid && out_ready)) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign out_wen = out_valid && out_ready && (out_rd != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations checked against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, kill, out_valid, out_ready, out_wen;
  logic [2:0]  in_op;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .kill(kill), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M reference semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      pa, pb;
    int          sa, sb;
    sa = a;
    sb = b;
    p  = '0;
    case (op)
      OP_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      OP_MULH:   begin pa = longint'(sa); pb = longint'(sb); p = pa * pb; return p[63:32]; end
      OP_MULHSU: begin pa = longint'(sa); pb = {32'b0, b}; p = pa * pb; return p[63:32]; end
      OP_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      OP_DIV:    begin
        if (b == 0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return a;
        return sa / sb;
      end
      OP_DIVU:   return (b == 0) ? 32'hffffffff : a / b;
      OP_REM:    begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
        return sa % sb;
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hffffffff));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hffffffff;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Drive one request for exactly one edge (called at a negedge), then scramble inputs.
  task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_op = 3'($urandom); in_a = $urandom; in_b = $urandom; in_rd = 5'($urandom);
  endtask

  // Full transaction: accept, measure latency, hold in DONE, consume.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input int hold, input string tag);
    int lat;
    int exp_lat;
    exp_lat = is_special(op, a, b) ? 1 : 32;
    check({tag, " in_ready before"}, 32'(in_ready), 32'd1);
    present(op, a, b, rd);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, out_result, exp);
    check({tag, " rd"}, 32'(out_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_op = OP_MUL; in_a = 32'd7; in_b = 32'd9; in_rd = 5'd1;
      @(posedge clk);
      @(negedge clk);
      check({tag, " held result"}, out_result, exp);
      check({tag, " held rd"}, 32'(out_rd), 32'(rd));
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check({tag, " wen"}, 32'(out_wen), (rd != 5'd0) ? 32'd1 : 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after consume"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    rst = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_result", out_result, 32'h0);
    check("reset out_rd", 32'(out_rd), 32'd0);

    // Reset held three cycles in the middle of a divide.
    present(OP_DIV, 32'd100, 32'd7, 5'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("midreset out_valid", 32'(out_valid), 32'd0);
      check("midreset out_wen", 32'(out_wen), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("postreset in_ready", 32'(in_ready), 32'd1);
    check("postreset out_valid", 32'(out_valid), 32'd0);
    check("postreset out_result", out_result, 32'h0);
    check("postreset out_rd", 32'(out_rd), 32'd0);
    repeat (40) @(negedge clk);
    check("postreset no late result", 32'(out_valid), 32'd0);
    check("postreset no wen", 32'(out_wen), 32'd0);
    out_ready = 1'b0;

    // Multiply corners.
    run_op(OP_MUL,    32'hffffffff, 32'd2,        5'd5, 32'hfffffffe, 0, "mul");
    run_op(OP_MULH,   32'hffffffff, 32'd2,        5'd5, 32'hffffffff, 0, "mulh");
    run_op(OP_MULHU,  32'hffffffff, 32'd2,        5'd5, 32'h00000001, 0, "mulhu");
    run_op(OP_MULHSU, 32'hffffffff, 32'hffffffff, 5'd6, 32'hffffffff, 0, "mulhsu");

    // Divide corners.
    run_op(OP_DIV,  32'hfffffff9, 32'd2, 5'd7, 32'hfffffffd, 0, "div neg");
    run_op(OP_REM,  32'hfffffff9, 32'd2, 5'd7, 32'hffffffff, 0, "rem neg");
    run_op(OP_DIVU, 32'hfffffff9, 32'd2, 5'd8, 32'h7ffffffc, 0, "divu");
    run_op(OP_REMU, 32'hfffffff9, 32'd2, 5'd8, 32'h00000001, 0, "remu");

    // Special cases with single-cycle latency.
    run_op(OP_DIV,  32'd5,        32'd0,        5'd9,  32'hffffffff, 0, "div by zero");
    run_op(OP_REMU, 32'd5,        32'd0,        5'd9,  32'h00000005, 0, "remu by zero");
    run_op(OP_DIV,  32'h80000000, 32'hffffffff, 5'd10, 32'h80000000, 0, "div overflow");
    run_op(OP_REM,  32'h80000000, 32'hffffffff, 5'd10, 32'h00000000, 0, "rem overflow");

    // Backpressure: hold DONE for ten cycles with in_valid asserted.
    run_op(OP_MUL, 32'd3, 32'd5, 5'd7, 32'd15, 10, "backpressure");
    // rd = 0 executes but never writes.
    run_op(OP_DIVU, 32'd50, 32'd6, 5'd0, 32'd8, 2, "rd zero");

    // kill in IDLE blocks acceptance.
    in_valid = 1'b1; in_op = OP_MUL; in_a = 32'd1; in_b = 32'd1; in_rd = 5'd2; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; kill = 1'b0;
    check("idle kill in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);
    check("idle kill no result", 32'(out_valid), 32'd0);

    // kill at CALC cycle 10, then an immediate new operation.
    present(OP_DIV, 32'd1000, 32'd7, 5'd4);
    repeat (9) @(negedge clk);
    check("kill pre out_valid", 32'(out_valid), 32'd0);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check("kill out_valid", 32'(out_valid), 32'd0);
    check("kill in_ready", 32'(in_ready), 32'd1);
    run_op(OP_MUL, 32'd3, 32'd4, 5'd11, 32'd12, 0, "after kill");

    // kill while holding a finished result.
    present(OP_DIVU, 32'd9, 32'd0, 5'd12);
    repeat (3) @(negedge clk);
    check("done kill pre out_valid", 32'(out_valid), 32'd1);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check("done kill out_valid", 32'(out_valid), 32'd0);
    check("done kill in_ready", 32'(in_ready), 32'd1);

    // Random operations against the reference model.
    for (int n = 0; n < 48; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      rd = 5'($urandom);
      run_op(op, a, b, rd, model(op, a, b), $urandom_range(0, 2), $sformatf("rand%0d op%0d", n, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
